// File: rtl/swacc_mr_cmd_dispatch_pkg.sv
// Shared MR command dispatch definitions: head field layout, type/opcode
// codes and FSM state encoding.
package swacc_mr_cmd_dispatch_pkg;

    localparam logic [3:0] MR_TYPE_MPT    = 4'h1;
    localparam logic [3:0] MR_TYPE_MTT    = 4'h2;

    localparam logic [3:0] WR_MPT_WRITE   = 4'h1;
    localparam logic [3:0] WR_MPT_INVALID = 4'h2;

    localparam int TYPE_HI = 127;
    localparam int TYPE_LO = 124;
    localparam int OPC_HI  = 123;
    localparam int OPC_LO  = 120;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MPT_FWD = 2'd1;
    localparam logic [1:0] ST_MTT_FWD = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    // Next state chosen from a command head sampled in IDLE.
    function automatic logic [1:0] decode_dest(input logic [3:0] typ,
                                               input logic [3:0] opc);
        logic [1:0] st;
        st = ST_DRAIN;
        if (typ == MR_TYPE_MTT)
            st = ST_MTT_FWD;
        else if (typ == MR_TYPE_MPT &&
                 (opc == WR_MPT_WRITE || opc == WR_MPT_INVALID))
            st = ST_MPT_FWD;
        return st;
    endfunction

endpackage

// File: rtl/swacc_mr_cmd_dispatch_buf.sv
// mr_beat_buf: single-entry valid/ready register slice for data + last.
// Accepts a new beat in the same cycle the held one is handed off.
module mr_beat_buf #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/swacc_mr_cmd_dispatch.sv
// CEU MR command dispatcher: routes each head+data command to the MPT or
// MTT write thread, drains illegal commands and counts errors.
module swacc_mr_cmd_dispatch
    import swacc_mr_cmd_dispatch_pkg::*;
#(
    parameter int HEAD_W    = 128,
    parameter int DATA_W    = 256,
    parameter int MAX_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ceu_req_valid,
    input  logic [HEAD_W-1:0] ceu_req_head,
    input  logic              ceu_req_last,
    input  logic [DATA_W-1:0] ceu_req_data,
    output logic              ceu_req_ready,
    output logic              mpt_req_valid,
    output logic [HEAD_W-1:0] mpt_req_head,
    output logic              mpt_req_last,
    output logic [DATA_W-1:0] mpt_req_data,
    input  logic              mpt_req_ready,
    output logic              mtt_req_valid,
    output logic [HEAD_W-1:0] mtt_req_head,
    output logic              mtt_req_last,
    output logic [DATA_W-1:0] mtt_req_data,
    input  logic              mtt_req_ready,
    output logic              err_pulse,
    output logic [15:0]       err_cnt
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic [1:0]        state;
    logic [HEAD_W-1:0] head_reg;
    logic [CNT_W-1:0]  beat_cnt;
    logic              in_done;
    logic              ovf;

    logic              fwd;
    logic              sel_mpt;
    logic              sel_mtt;
    logic              dst_ready;
    logic              accept;
    logic              cap_beat;
    logic              hand_last;
    logic              err_evt;
    logic [1:0]        dest;
    logic              buf_in_valid;
    logic              buf_in_ready;
    logic              buf_in_last;
    logic              buf_valid;
    logic              buf_last;
    logic [DATA_W-1:0] buf_data;

    assign sel_mpt   = (state == ST_MPT_FWD);
    assign sel_mtt   = (state == ST_MTT_FWD);
    assign fwd       = sel_mpt || sel_mtt;
    assign dst_ready = sel_mpt ? mpt_req_ready : mtt_req_ready;
    assign dest      = decode_dest(ceu_req_head[TYPE_HI:TYPE_LO],
                                   ceu_req_head[OPC_HI:OPC_LO]);

    always_comb begin
        ceu_req_ready = 1'b0;
        unique case (state)
            ST_MPT_FWD, ST_MTT_FWD: ceu_req_ready = !in_done && buf_in_ready;
            ST_DRAIN:               ceu_req_ready = !in_done;
            default:                ceu_req_ready = 1'b0;
        endcase
    end

    assign accept       = ceu_req_valid && ceu_req_ready;
    assign buf_in_valid = fwd && ceu_req_valid && !in_done;
    // Beat MAX_BEATS without last closes the command early.
    assign cap_beat     = (beat_cnt == CNT_W'(MAX_BEATS - 1)) && !ceu_req_last;
    assign buf_in_last  = ceu_req_last || cap_beat;
    assign hand_last    = fwd && buf_valid && dst_ready && buf_last;
    assign err_evt      = (state == ST_IDLE && ceu_req_valid && dest == ST_DRAIN)
                       || (fwd && accept && cap_beat);

    mr_beat_buf #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (buf_in_valid),
        .in_data   (ceu_req_data),
        .in_last   (buf_in_last),
        .in_ready  (buf_in_ready),
        .out_valid (buf_valid),
        .out_data  (buf_data),
        .out_last  (buf_last),
        .out_ready (fwd && dst_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            head_reg <= '0;
            beat_cnt <= '0;
            in_done  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ceu_req_valid) begin
                        head_reg <= ceu_req_head;
                        beat_cnt <= '0;
                        in_done  <= 1'b0;
                        ovf      <= 1'b0;
                        state    <= dest;
                    end
                end
                ST_MPT_FWD, ST_MTT_FWD: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (buf_in_last) in_done <= 1'b1;
                        if (cap_beat)    ovf     <= 1'b1;
                    end
                    if (hand_last) begin
                        state   <= ovf ? ST_DRAIN : ST_IDLE;
                        in_done <= 1'b0;
                    end
                end
                default: begin
                    if (accept && ceu_req_last) state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= err_evt;
            if (err_evt && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

    assign mpt_req_valid = sel_mpt && buf_valid;
    assign mpt_req_head  = sel_mpt ? head_reg : '0;
    assign mpt_req_data  = sel_mpt ? buf_data : '0;
    assign mpt_req_last  = sel_mpt && buf_last;

    assign mtt_req_valid = sel_mtt && buf_valid;
    assign mtt_req_head  = sel_mtt ? head_reg : '0;
    assign mtt_req_data  = sel_mtt ? buf_data : '0;
    assign mtt_req_last  = sel_mtt && buf_last;

endmodule

// File: tb/tb_swacc_mr_cmd_dispatch.sv
// Scoreboard bench for swacc_mr_cmd_dispatch: expected beats are queued at
// drive time and checked as each destination handshake completes.
module tb_swacc_mr_cmd_dispatch;

    typedef struct packed {
        logic         ch;
        logic [127:0] head;
        logic [255:0] data;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ceu_req_valid = 1'b0;
    logic [127:0] ceu_req_head = '0;
    logic         ceu_req_last = 1'b0;
    logic [255:0] ceu_req_data = '0;
    logic         ceu_req_ready;
    logic         mpt_req_valid;
    logic [127:0] mpt_req_head;
    logic         mpt_req_last;
    logic [255:0] mpt_req_data;
    logic         mpt_req_ready = 1'b1;
    logic         mtt_req_valid;
    logic [127:0] mtt_req_head;
    logic         mtt_req_last;
    logic [255:0] mtt_req_data;
    logic         mtt_req_ready = 1'b1;
    logic         err_pulse;
    logic [15:0]  err_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = -1;
    int   first_valid_cyc = -1;
    int   mpt_xfers = 0;
    int   mtt_xfers = 0;
    int   mpt_vcyc = 0;
    int   err_pulses = 0;
    bit   tog_mtt = 1'b0;
    exp_t sb[$];

    swacc_mr_cmd_dispatch dut (
        .clk           (clk),
        .rst           (rst),
        .ceu_req_valid (ceu_req_valid),
        .ceu_req_head  (ceu_req_head),
        .ceu_req_last  (ceu_req_last),
        .ceu_req_data  (ceu_req_data),
        .ceu_req_ready (ceu_req_ready),
        .mpt_req_valid (mpt_req_valid),
        .mpt_req_head  (mpt_req_head),
        .mpt_req_last  (mpt_req_last),
        .mpt_req_data  (mpt_req_data),
        .mpt_req_ready (mpt_req_ready),
        .mtt_req_valid (mtt_req_valid),
        .mtt_req_head  (mtt_req_head),
        .mtt_req_last  (mtt_req_last),
        .mtt_req_data  (mtt_req_data),
        .mtt_req_ready (mtt_req_ready),
        .err_pulse     (err_pulse),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tog_mtt) mtt_req_ready = ~mtt_req_ready;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (mpt_req_valid) mpt_vcyc++;
        if (err_pulse) err_pulses++;
        if ((mpt_req_valid || mtt_req_valid) && first_valid_cyc < 0)
            first_valid_cyc = cyc;
        if (mpt_req_valid && mpt_req_ready) begin
            mpt_xfers++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL mpt_unexpected: got head=%h, required no beat", mpt_req_head);
            end else begin
                e = sb.pop_front();
                if (e.ch !== 1'b0 || mpt_req_head !== e.head ||
                    mpt_req_data !== e.data || mpt_req_last !== e.last) begin
                    errors++;
                    $display("FAIL mpt_beat: got ch=0 head=%h data=%h last=%b, required ch=%b head=%h data=%h last=%b",
                             mpt_req_head, mpt_req_data, mpt_req_last, e.ch, e.head, e.data, e.last);
                end
            end
        end
        if (mtt_req_valid && mtt_req_ready) begin
            mtt_xfers++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL mtt_unexpected: got head=%h, required no beat", mtt_req_head);
            end else begin
                e = sb.pop_front();
                if (e.ch !== 1'b1 || mtt_req_head !== e.head ||
                    mtt_req_data !== e.data || mtt_req_last !== e.last) begin
                    errors++;
                    $display("FAIL mtt_beat: got ch=1 head=%h data=%h last=%b, required ch=%b head=%h data=%h last=%b",
                             mtt_req_head, mtt_req_data, mtt_req_last, e.ch, e.head, e.data, e.last);
                end
            end
        end
    end

    function automatic logic [127:0] mk_head(input logic [3:0] t,
                                             input logic [3:0] o,
                                             input logic [31:0] idx);
        logic [127:0] h;
        h = '0;
        h[127:124] = t;
        h[123:120] = o;
        h[31:0] = idx;
        return h;
    endfunction

    task automatic drive_cmd(input logic [127:0] h, input int n,
                             input int nfwd, input logic ch, output int acc);
        logic [255:0] d;
        exp_t         e;
        int           guard;
        acc = 0;
        start_cyc = -1;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
            if (i < nfwd) begin
                e.ch = ch;
                e.head = h;
                e.data = d;
                e.last = (i == nfwd - 1);
                sb.push_back(e);
            end
            @(negedge clk);
            ceu_req_valid = 1'b1;
            ceu_req_head = h;
            ceu_req_data = d;
            ceu_req_last = (i == n - 1);
            if (start_cyc < 0) start_cyc = cyc;
            guard = 0;
            #1;
            while (!ceu_req_ready && guard < 100) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (guard >= 100) begin
                checks++;
                errors++;
                $display("FAIL beat_accept_timeout: beat %0d never accepted, required accept", i);
            end else begin
                acc++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        ceu_req_valid = 1'b0;
        ceu_req_last = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic clear_stats();
        mpt_xfers = 0;
        mtt_xfers = 0;
        mpt_vcyc = 0;
        err_pulses = 0;
        first_valid_cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({mpt_req_valid, mtt_req_valid, ceu_req_ready, err_pulse} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got mv=%b tv=%b rdy=%b ep=%b, required 0",
                     mpt_req_valid, mtt_req_valid, ceu_req_ready, err_pulse);
        end
        checks++;
        if (mpt_req_head !== '0 || mpt_req_data !== '0 || mpt_req_last !== 1'b0 ||
            mtt_req_head !== '0 || mtt_req_data !== '0 || mtt_req_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_payload: got nonzero head/data/last, required 0");
        end
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mpt_write();
        int acc;
        clear_stats();
        mpt_req_ready = 1'b1;
        mtt_req_ready = 1'b1;
        drive_cmd(mk_head(4'h1, 4'h1, 32'h12), 2, 2, 1'b0, acc);
        wait_drain("mpt_write");
        checks++;
        if (first_valid_cyc - start_cyc != 2) begin
            errors++;
            $display("FAIL mpt_write_latency: got %0d, required 2", first_valid_cyc - start_cyc);
        end
        checks++;
        if (mpt_vcyc != 2 || mpt_xfers != 2 || mtt_xfers != 0) begin
            errors++;
            $display("FAIL mpt_write_counts: got vcyc=%0d mpt=%0d mtt=%0d, required 2 2 0",
                     mpt_vcyc, mpt_xfers, mtt_xfers);
        end
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mpt_write_err_cnt: got %0d, required 0", err_cnt);
        end
    endtask

    task automatic test_mpt_stall();
        int acc;
        clear_stats();
        mpt_req_ready = 1'b0;
        drive_cmd(mk_head(4'h1, 4'h2, 32'h34), 1, 1, 1'b0, acc);
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++;
            if (mpt_req_valid !== 1'b1 || ceu_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL mpt_stall_hold: cycle %0d got valid=%b ready=%b, required 1 0",
                         i, mpt_req_valid, ceu_req_ready);
            end
            @(negedge clk);
        end
        mpt_req_ready = 1'b1;
        @(negedge clk);
        #2;
        checks++;
        if (mpt_req_valid !== 1'b0 || mpt_xfers != 1 || dut.state !== 2'd0) begin
            errors++;
            $display("FAIL mpt_stall_release: got valid=%b xfers=%0d state=%0d, required 0 1 0",
                     mpt_req_valid, mpt_xfers, dut.state);
        end
        wait_drain("mpt_stall");
    endtask

    task automatic test_mtt_toggle();
        int acc;
        clear_stats();
        tog_mtt = 1'b1;
        drive_cmd(mk_head(4'h2, 4'h7, 32'h56), 4, 4, 1'b1, acc);
        wait_drain("mtt_toggle");
        tog_mtt = 1'b0;
        mtt_req_ready = 1'b1;
        checks++;
        if (mtt_xfers != 4 || mpt_vcyc != 0) begin
            errors++;
            $display("FAIL mtt_toggle_counts: got mtt=%0d mpt_vcyc=%0d, required 4 0",
                     mtt_xfers, mpt_vcyc);
        end
    endtask

    task automatic test_illegal();
        int acc;
        clear_stats();
        drive_cmd(mk_head(4'hF, 4'h0, 32'h78), 3, 0, 1'b0, acc);
        wait_drain("illegal");
        checks++;
        if (acc != 3 || err_pulses != 1 || err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL illegal_drain: got acc=%0d pulses=%0d err_cnt=%0d, required 3 1 1",
                     acc, err_pulses, err_cnt);
        end
        checks++;
        if (mpt_xfers != 0 || mtt_xfers != 0 || first_valid_cyc >= 0) begin
            errors++;
            $display("FAIL illegal_output: got mpt=%0d mtt=%0d, required no valid",
                     mpt_xfers, mtt_xfers);
        end
    endtask

    task automatic test_overlong();
        int acc;
        clear_stats();
        drive_cmd(mk_head(4'h2, 4'h3, 32'h9A), 6, 4, 1'b1, acc);
        wait_drain("overlong");
        checks++;
        if (acc != 6 || mtt_xfers != 4 || err_pulses != 1 || err_cnt !== 16'd2) begin
            errors++;
            $display("FAIL overlong: got acc=%0d mtt=%0d pulses=%0d err_cnt=%0d, required 6 4 1 2",
                     acc, mtt_xfers, err_pulses, err_cnt);
        end
        checks++;
        if (dut.state !== 2'd0) begin
            errors++;
            $display("FAIL overlong_state: got %0d, required 0", dut.state);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int guard;
        clear_stats();
        mpt_req_ready = 1'b0;
        @(negedge clk);
        ceu_req_valid = 1'b1;
        ceu_req_head = mk_head(4'h1, 4'h1, 32'hBC);
        ceu_req_data = {8{32'hDEADBEEF}};
        ceu_req_last = 1'b0;
        guard = 0;
        #1;
        while (!ceu_req_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
        ceu_req_valid = 1'b0;
        #2;
        checks++;
        if (mpt_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got valid=%b, required 1", mpt_req_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mpt_req_valid !== 1'b0 || mpt_req_head !== '0 || mpt_req_data !== '0 ||
            ceu_req_ready !== 1'b0 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got valid=%b rdy=%b err_cnt=%0d, required all 0",
                     mpt_req_valid, ceu_req_ready, err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        mpt_req_ready = 1'b1;
        @(negedge clk);
        clear_stats();
        drive_cmd(mk_head(4'h1, 4'h1, 32'hBC), 2, 2, 1'b0, acc);
        wait_drain("reset_mid");
        checks++;
        if (mpt_xfers != 2) begin
            errors++;
            $display("FAIL reset_mid_resend: got xfers=%0d, required 2", mpt_xfers);
        end
    endtask

    initial begin
        test_reset();
        test_mpt_write();
        test_mpt_stall();
        test_mtt_toggle();
        test_illegal();
        test_overlong();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
